// File: rtl/mmcm_drp_sequencer.sv
// mmcm_drp_sequencer
//
// Purpose: reprograms the CLKOUT0..3 ClkReg1 divide fields of an MMCM over
// its DRP port. Each field is updated read-modify-write while the MMCM is
// held in reset. The block then waits for LOCKED and holds clk_ok off for a
// settle interval. The same lock/settle path is used at power-up and to
// recover after a lock drop while idle.
//
// Optional feature: define DRP_TIMEOUT_EN to add a DRDY watchdog. If it
// expires, the block enters ERROR and sets the sticky err flag. When the
// macro is undefined, the block waits for DRDY indefinitely and err is tied
// to 0.
//
// Parameters:
//   SETTLE_LOG2    - clk_ok hold-off after lock is 2^SETTLE_LOG2 cycles
//   TIMEOUT_CYCLES - DRDY watchdog limit (used only with DRP_TIMEOUT_EN)
//
// Ports:
//   clk        in   single clock for all logic
//   reset      in   synchronous active-high reset
//   req        in   start reconfiguration (accepted in IDLE only)
//   sel        in   profile select, captured with req
//   busy       out  reconfiguration in progress
//   done       out  one-cycle pulse on successful completion
//   err        out  sticky DRP timeout flag
//   clk_ok     out  MMCM locked and settled
//   mmcm_rst   out  MMCM RST drive
//   drp_den    out  DRP enable pulse
//   drp_dwe    out  DRP write enable, pulsed with drp_den on writes
//   drp_daddr  out  DRP address
//   drp_di     out  DRP write data
//   drp_do     in   DRP read data, valid with drp_drdy
//   drp_drdy   in   DRP transaction complete
//   locked     in   MMCM LOCKED
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | locked and settled, waiting for req
// RST_ASSERT | MMCM held in reset, first read is being issued
// READ       | drp_den read pulse for entry idx
// WAIT_RD    | waiting for read drp_drdy
// WRITE      | drp_den/drp_dwe write pulse for entry idx
// WAIT_WR    | waiting for write drp_drdy
// NEXT       | advance to next entry or finish the table
// RELEASE    | last cycle with mmcm_rst high
// WAIT_LOCK  | waiting for LOCKED
// SETTLE     | counting the hold-off interval with LOCKED high
// DONE       | clk_ok raised, done pulsed if a request was active
// ERROR      | DRDY watchdog expired (DRP_TIMEOUT_EN only)

module mmcm_drp_sequencer #(
  parameter int SETTLE_LOG2    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        clk_ok,
  output logic        mmcm_rst,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  input  logic        locked
);

  typedef enum logic [3:0] {
    IDLE, RST_ASSERT, READ, WAIT_RD, WRITE, WAIT_WR,
    NEXT, RELEASE, WAIT_LOCK, SETTLE, DONE, ERROR
  } state_t;

  localparam int SETTLE_W = SETTLE_LOG2 + 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'((1 << SETTLE_LOG2) - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t              state;
  logic                sel_q;
  logic [1:0]          idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [5:0]          half;

  // Half of the output divide D. High time and low time are both D/2.
  function automatic logic [5:0] half_div(input logic s, input logic [1:0] i);
    logic [5:0] h;
    case ({s, i})
      3'b000:  h = 6'd5;
      3'b001:  h = 6'd10;
      3'b010:  h = 6'd20;
      3'b011:  h = 6'd40;
      3'b100:  h = 6'd10;
      3'b101:  h = 6'd20;
      3'b110:  h = 6'd40;
      default: h = 6'd60;
    endcase
    return h;
  endfunction

  function automatic logic [6:0] entry_addr(input logic [1:0] i);
    return 7'h08 + {4'b0000, i, 1'b0};
  endfunction

  assign half = half_div(sel_q, idx);

`ifdef DRP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      busy       <= 1'b0;
      done       <= 1'b0;
      clk_ok     <= 1'b0;
      mmcm_rst   <= 1'b0;
      drp_den    <= 1'b0;
      drp_dwe    <= 1'b0;
      drp_daddr  <= '0;
      drp_di     <= '0;
      sel_q      <= 1'b0;
      idx        <= '0;
      settle_cnt <= '0;
`ifdef DRP_TIMEOUT_EN
      err        <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      done    <= 1'b0;
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      case (state)
        IDLE: begin
          // A lock loss takes priority over a new request.
          if (!locked) begin
            clk_ok <= 1'b0;
            state  <= WAIT_LOCK;
          end else if (req) begin
            sel_q    <= sel;
            idx      <= '0;
            busy     <= 1'b1;
            mmcm_rst <= 1'b1;
            clk_ok   <= 1'b0;
            state    <= RST_ASSERT;
          end
        end
        RST_ASSERT: begin
          drp_den   <= 1'b1;
          drp_daddr <= entry_addr(idx);
          state     <= READ;
        end
        READ: begin
`ifdef DRP_TIMEOUT_EN
          wd_cnt <= WD_LOAD;
`endif
          state <= WAIT_RD;
        end
        WAIT_RD: begin
          if (drp_drdy) begin
            // Keep the upper nibble of ClkReg1 and replace the high/low times.
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            drp_di  <= (drp_do & 16'hF000) | {4'b0000, half, half};
            state   <= WRITE;
          end
`ifdef DRP_TIMEOUT_EN
          else if (wd_cnt == '0) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            mmcm_rst <= 1'b0;
            state    <= ERROR;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
`endif
        end
        WRITE: begin
`ifdef DRP_TIMEOUT_EN
          wd_cnt <= WD_LOAD;
`endif
          state <= WAIT_WR;
        end
        WAIT_WR: begin
          if (drp_drdy) begin
            state <= NEXT;
          end
`ifdef DRP_TIMEOUT_EN
          else if (wd_cnt == '0) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            mmcm_rst <= 1'b0;
            state    <= ERROR;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
`endif
        end
        NEXT: begin
          if (idx == 2'd3) begin
            state <= RELEASE;
          end else begin
            idx       <= idx + 2'd1;
            drp_den   <= 1'b1;
            drp_daddr <= entry_addr(idx + 2'd1);
            state     <= READ;
          end
        end
        RELEASE: begin
          mmcm_rst <= 1'b0;
          state    <= WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked) begin
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (!locked) begin
            settle_cnt <= '0;
            state      <= WAIT_LOCK;
          end else if (settle_cnt == '0) begin
            // Power-up and idle recovery reach DONE with busy low, so no pulse.
            clk_ok <= 1'b1;
            done   <= busy;
            state  <= DONE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
`ifdef DRP_TIMEOUT_EN
        ERROR: begin
          state <= WAIT_LOCK;
        end
`endif
        default: begin
          state <= WAIT_LOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Testbench for mmcm_drp_sequencer: cycle vector table for power-up and idle
// lock loss, directed and randomized reconfigurations checked against a
// behavioural model, reset corner cases, and the DRDY watchdog when
// DRP_TIMEOUT_EN is defined.

module tb_mmcm_drp_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset, req, sel, locked;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic        busy, done, err, clk_ok, mmcm_rst, drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;

  mmcm_drp_sequencer #(.SETTLE_LOG2(2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .sel(sel),
    .busy(busy), .done(done), .err(err), .clk_ok(clk_ok),
    .mmcm_rst(mmcm_rst), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do),
    .drp_drdy(drp_drdy), .locked(locked)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference table of output divides per profile and entry.
  int divs [2][4] = '{'{10, 20, 40, 80}, '{20, 40, 80, 120}};

  function automatic logic [22:0] expect_write(input bit s, input int i, input logic [15:0] rd);
    int d;
    int h;
    d = divs[s][i];
    h = d / 2;
    return {7'(8 + 2 * i), 16'(int'(rd & 16'hF000) + h * 64 + h)};
  endfunction

  // DRP slave model
  int          resp_lat   = 2;
  bit          resp_fixed = 1'b1;
  logic [15:0] resp_val   = 16'hA000;
  bit          resp_hold  = 1'b0;
  logic [15:0] rd_log[$];

  initial begin
    bit          is_wr;
    int          n;
    logic [15:0] v;
    drp_drdy = 1'b0;
    drp_do   = 16'h0000;
    @(negedge clk);
    forever begin
      if (drp_den && !reset && !resp_hold) begin
        is_wr = drp_dwe;
        n = (resp_lat > 0) ? resp_lat : int'($urandom_range(4, 1));
        repeat (n) @(negedge clk);
        v = resp_fixed ? resp_val : 16'($urandom);
        drp_do   = v;
        drp_drdy = 1'b1;
        if (!is_wr) rd_log.push_back(v);
        @(negedge clk);
        drp_drdy = 1'b0;
        drp_do   = 16'($urandom);
      end else begin
        @(negedge clk);
      end
    end
  end

  // Bus monitor
  int          den_cnt  = 0;
  int          done_cnt = 0;
  int          viol     = 0;
  logic [22:0] wr_log[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (drp_den) begin
          den_cnt++;
          if (drp_dwe) wr_log.push_back({drp_daddr, drp_di});
          if (!mmcm_rst || !busy) viol++;
        end
        if (mmcm_rst && clk_ok) viol++;
        if (done) done_cnt++;
      end
    end
  end

  typedef struct packed {
    logic       rst;
    logic       lck;
    logic       rq;
    logic       sl;
    logic [5:0] exp;   // {busy, done, clk_ok, mmcm_rst, drp_den, err}
  } vec_t;

  vec_t        vecs[$];
  logic [22:0] last_wr [4];

  task automatic add_vec(input logic r, input logic l, input logic q, input logic s,
                         input int reps, input logic [5:0] e);
    vec_t v;
    v.rst = r; v.lck = l; v.rq = q; v.sl = s; v.exp = e;
    for (int k = 0; k < reps; k++) vecs.push_back(v);
  endtask

  task automatic run_reconfig(input string tag, input bit sel_v, input int relock_dly,
                              input bit glitch, input bit extra_req);
    int den0, done0, viol0, wr0, rd0;
    int t, rel_t, phase, cnt, gl;
    bit seen_rst, finished;
    logic [15:0] rd;
    @(negedge clk);
    #1;
    den0 = den_cnt; done0 = done_cnt; viol0 = viol;
    wr0 = wr_log.size(); rd0 = rd_log.size();
    req = 1'b1;
    sel = sel_v;
    @(negedge clk);
    req = 1'b0;
    sel = 1'($urandom);
    t = 1; phase = 0; cnt = 0; gl = 0; rel_t = 0;
    seen_rst = 1'b0; finished = 1'b0;
    while (!finished && t < 3000) begin
      if (clk_ok && phase == 3) begin
        check({tag, "_settle_delay"}, t - rel_t, 5);
        check({tag, "_done_with_clk_ok"}, done, 1'b1);
        finished = 1'b1;
      end else begin
        if (mmcm_rst) begin
          locked   = 1'b0;
          seen_rst = 1'b1;
        end
        case (phase)
          0: if (seen_rst && !mmcm_rst) begin phase = 1; cnt = relock_dly; end
          1: begin
            cnt--;
            if (cnt <= 0) begin
              locked = 1'b1; rel_t = t; gl = 0;
              phase = glitch ? 2 : 3;
            end
          end
          2: begin
            gl++;
            if (gl == 2) locked = 1'b0;
            else if (gl == 3) begin locked = 1'b1; rel_t = t; phase = 3; end
          end
          default: ;
        endcase
        if (extra_req && t == 6) begin
          req = 1'b1;
          sel = ~sel_v;
        end else begin
          req = 1'b0;
        end
        @(negedge clk);
        t++;
      end
    end
    req = 1'b0;
    if (!finished) begin
      chk_cnt++;
      $display("FAIL %s_no_clk_ok: %0d cycles without clk_ok, want it after relock", tag, t);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    check({tag, "_drp_transactions"}, den_cnt - den0, 8);
    check({tag, "_done_pulses"}, done_cnt - done0, 1);
    check({tag, "_protocol_violations"}, viol - viol0, 0);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_clk_ok_end"}, clk_ok, 1'b1);
    check({tag, "_write_count"}, wr_log.size() - wr0, 4);
    for (int i = 0; i < 4; i++) begin
      last_wr[i] = 23'h0;
      if (wr0 + i < wr_log.size()) begin
        last_wr[i] = wr_log[wr0 + i];
        rd = (rd0 + i < rd_log.size()) ? rd_log[rd0 + i] : 16'h0000;
        check($sformatf("%s_write%0d", tag, i), last_wr[i], expect_write(sel_v, i, rd));
      end
    end
  endtask

  initial begin
    int d1, done0, den0, t, t_den;
    reset  = 1'b1;
    req    = 1'b0;
    sel    = 1'b0;
    locked = 1'b0;

    // Power-up with locked rising at cycle 10, then a lock loss in IDLE.
    add_vec(1, 0, 0, 0, 1, 6'b000000);
    add_vec(1, 1, 1, 1, 1, 6'b000000);
    add_vec(0, 0, 0, 0, 8, 6'b000000);
    add_vec(0, 1, 0, 0, 4, 6'b000000);
    add_vec(0, 1, 0, 0, 2, 6'b001000);
    add_vec(0, 0, 0, 0, 1, 6'b000000);
    add_vec(0, 0, 1, 1, 1, 6'b000000);
    add_vec(0, 1, 0, 0, 4, 6'b000000);
    add_vec(0, 1, 0, 0, 2, 6'b001000);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      locked = vecs[i].lck;
      req    = vecs[i].rq;
      sel    = vecs[i].sl;
      @(negedge clk);
      check($sformatf("vec%0d", i), {busy, done, clk_ok, mmcm_rst, drp_den, err}, vecs[i].exp);
    end
    req = 1'b0;
    #1;
    check("powerup_done_pulses", done_cnt, 0);

    // Directed profile 0, fixed read data and latency.
    resp_fixed = 1'b1; resp_val = 16'hA000; resp_lat = 2;
    run_reconfig("sel0", 1'b0, 3, 1'b0, 1'b0);
    check("sel0_w0", last_wr[0], {7'h08, 16'hA145});
    check("sel0_w1", last_wr[1], {7'h0A, 16'hA28A});
    check("sel0_w2", last_wr[2], {7'h0C, 16'hA514});
    check("sel0_w3", last_wr[3], {7'h0E, 16'hAA28});

    // Directed profile 1 with zero read data.
    resp_val = 16'h0000; resp_lat = 1;
    run_reconfig("sel1", 1'b1, 2, 1'b0, 1'b0);
    check("sel1_w0", last_wr[0], {7'h08, 16'h028A});
    check("sel1_w3", last_wr[3], {7'h0E, 16'h0F3C});

    // Lock glitch in SETTLE plus a req while busy.
    resp_fixed = 1'b0; resp_lat = 0;
    run_reconfig("glitch_busyreq", 1'b0, 1, 1'b1, 1'b1);

    for (int r = 0; r < 16; r++) begin
      run_reconfig($sformatf("rnd%0d", r), 1'($urandom), int'($urandom_range(6, 1)),
                   1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a reconfiguration.
    resp_lat = 3;
    @(negedge clk);
    #1;
    done0 = done_cnt;
    req = 1'b1; sel = 1'b0;
    @(negedge clk);
    req = 1'b0;
    repeat (6) begin
      if (mmcm_rst) locked = 1'b0;
      @(negedge clk);
    end
    check("rstmid_active", mmcm_rst, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_outputs", {busy, done, clk_ok, mmcm_rst, drp_den}, 5'b00000);
    reset = 1'b0;
    #1;
    d1 = den_cnt;
    repeat (10) @(negedge clk);
    #1;
    check("rstmid_no_more_drp", den_cnt, d1);
    locked = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_clk_ok_early", clk_ok, 1'b0);
    @(negedge clk);
    check("rstmid_clk_ok", clk_ok, 1'b1);
    #1;
    check("rstmid_no_done", done_cnt, done0);

    // Reset together with req in IDLE.
    @(negedge clk);
    reset = 1'b1; req = 1'b1;
    @(negedge clk);
    check("rst_req_outputs", {busy, mmcm_rst, clk_ok}, 3'b000);
    reset = 1'b0; req = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_req_clk_ok_early", clk_ok, 1'b0);
    @(negedge clk);
    check("rst_req_clk_ok", clk_ok, 1'b1);

`ifdef DRP_TIMEOUT_EN
    resp_hold = 1'b1;
    @(negedge clk);
    #1;
    done0 = done_cnt; den0 = den_cnt;
    req = 1'b1; sel = 1'b1;
    @(negedge clk);
    req = 1'b0;
    t = 1; t_den = -1;
    while (t < 400 && !err) begin
      if (mmcm_rst) locked = 1'b0;
      if (drp_den && t_den < 0) t_den = t;
      @(negedge clk);
      t++;
    end
    if (!err) begin
      chk_cnt++;
      $display("FAIL timeout_err: err still low after %0d cycles", t);
    end else begin
      check("timeout_delay", t - t_den, TIMEOUT + 1);
    end
    check("timeout_state", {mmcm_rst, busy}, 2'b00);
    #1;
    check("timeout_one_txn", den_cnt - den0, 1);
    repeat (3) @(negedge clk);
    check("timeout_err_sticky", err, 1'b1);
    locked = 1'b1;
    repeat (6) @(negedge clk);
    check("timeout_relock", {clk_ok, err}, 2'b11);
    #1;
    check("timeout_no_done", done_cnt, done0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("timeout_err_cleared", err, 1'b0);
    reset = 1'b0;
    resp_hold = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mmcm_drp_sequencer.md
MMCM_DRP_SEQUENCER -- requirements
Module: mmcm_drp_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_LOG2, default 2: clk_ok hold-off after lock is 2^SETTLE_LOG2 cycles.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: DRDY watchdog limit; used only under DRP_TIMEOUT_EN.
REQ-003 SHALL have ports, one per line:
- clk  in  1  single clock for all logic (100 MHz domain).
- reset  in  1  synchronous, active-high reset.
- req  in  1  start-reconfiguration request; sampled in IDLE only.
- sel  in  1  profile select; captured with req.
- busy  out  1  high from the accepted req until DONE/ERROR exits.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky DRP-timeout flag.
- clk_ok  out  1  high when MMCM is locked and settled.
- mmcm_rst  out  1  MMCM RST drive.
- drp_den  out  1  DRP enable, one-cycle pulse.
- drp_dwe  out  1  DRP write enable, pulsed with drp_den on writes.
- drp_daddr  out  7  DRP address.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data, valid with drp_drdy.
- drp_drdy  in  1  DRP transaction complete.
- locked  in  1  MMCM LOCKED.

Function
REQ-004 SHALL have states IDLE, RST_ASSERT, READ, WAIT_RD, WRITE, WAIT_WR, NEXT, RELEASE, WAIT_LOCK, SETTLE, DONE and ERROR.
REQ-005 SHALL move IDLE->RST_ASSERT on req=1, latching sel and clearing entry index i to 0; busy goes high the next cycle.
REQ-006 SHALL hold mmcm_rst=1 from RST_ASSERT through RELEASE inclusive; clk_ok=0 in all those states.
REQ-007 SHALL reconfigure four entries i=0..3 at drp_daddr 0x08, 0x0A, 0x0C, 0x0E (CLKOUT0..3 ClkReg1).
REQ-008 SHALL use divides D = 10/20/40/80 for sel=0 and 20/40/80/120 for sel=1.
REQ-009 SHALL pulse drp_den for one cycle with drp_dwe=0 in READ, then wait in WAIT_RD for drp_drdy.
REQ-010 SHALL, in WRITE, pulse drp_den=drp_dwe=1 for one cycle with drp_di = (captured drp_do & 0xF000) | ((D/2)<<6) | (D/2), then wait in WAIT_WR for drp_drdy.
REQ-011 SHALL go NEXT->READ with i+1 while i<3, and NEXT->RELEASE when i=3.
REQ-012 SHALL drive mmcm_rst=0 on the RELEASE->WAIT_LOCK transition.
REQ-013 SHALL hold drp_den=0 outside READ/WRITE; at most one DRP transaction is outstanding.
REQ-014 SHALL move WAIT_LOCK->SETTLE on locked=1, then count 2^SETTLE_LOG2 cycles with locked held high, then enter DONE.
REQ-015 SHALL assert clk_ok from the cycle after SETTLE completes and pulse done for one cycle in DONE (when busy); DONE->IDLE.
REQ-016 SHALL, on a locked drop in SETTLE, return to WAIT_LOCK with the counter cleared.
REQ-017 SHALL, on a locked drop while in IDLE, deassert clk_ok next cycle and enter WAIT_LOCK with busy=0; done is not pulsed on recovery.
REQ-018 SHALL ignore req when not in IDLE; sel changes after acceptance have no effect.
REQ-019 SHALL ignore drp_drdy outside WAIT_RD/WAIT_WR.

Reset
REQ-020 SHALL make reset override all inputs, including a simultaneous req.
REQ-021 SHALL drive these values on reset: state=WAIT_LOCK (power-up path), busy=0, done=0, err=0, clk_ok=0, mmcm_rst=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, i=0, counters=0.
REQ-022 SHALL, on reset mid-reconfiguration, release mmcm_rst next cycle and abandon the DRP transaction.

Configuration
REQ-023 SHALL, with DRP_TIMEOUT_EN defined, use a watchdog in WAIT_RD/WAIT_WR: after TIMEOUT_CYCLES cycles with no drp_drdy, go to ERROR.
REQ-024 SHALL, in ERROR: mmcm_rst=0, err=1 (sticky until reset), busy=0, no done pulse, then WAIT_LOCK.
REQ-025 SHALL, without DRP_TIMEOUT_EN, wait indefinitely for drp_drdy, tie err to 0 and omit ERROR/watchdog logic.

Verification
REQ-026 SHALL cover power-up: reset, then locked=1 at cycle 10 -> clk_ok=1 at cycle 15 (SETTLE_LOG2=2), done never pulses.
REQ-027 SHALL cover req with sel=0 and drp_do=0xA000, drdy 2 cycles after each den -> writes 0xA145, 0xA28A, 0xA514, 0xAA28 to 0x08, 0x0A, 0x0C, 0x0E in order, then one done pulse.
REQ-028 SHALL cover sel=1 -> entry 3 write of 0x0F3C (drp_do=0x0000); mmcm_rst=1 throughout all writes.
REQ-029 SHALL cover locked dropping during SETTLE for 1 cycle -> counter restarts; clk_ok is delayed by a full 4 cycles after relock.
REQ-030 SHALL cover req pulsed while busy -> ignored, exactly 8 DRP transactions occur.
REQ-031 SHALL cover, with DRP_TIMEOUT_EN, drdy withheld on the first read -> err=1 after 64 cycles, mmcm_rst=0, busy=0, no done pulse.
